ball_controller: RTL and testbench
==================================

// Module: ball_controller
// PURPOSE
//  Owns ball position/direction for the breakout playfield. Once per frame it drives
//  probe coordinates into collision_detector (its hcount_in/vcount_in), samples the
//  registered collision_det, reflects on block edges and screen walls, then moves
//  the ball 1 px per axis. Ball position goes downstream to the ball draw stage.
// PARAMETERS
//  SCREEN_W   800  playfield width, px
//  SCREEN_H   600  playfield height, px
//  BALL_SIZE  8    square ball side, px (even)
//  START_X    396  ball x (top-left) after reset/start
//  START_Y    500  ball y (top-left) after reset/start
//  DET_LAT    1    pclk cycles from probe_h/probe_v valid to collision_det valid (1..3)
// PORTS
//  pclk           in   1   pixel clock, sole clock
//  rst            in   1   synchronous, active-high reset
//  start          in   1   1-cycle pulse: (re)serve ball
//  frame_tick     in   1   1-cycle pulse per frame (vblank start)
//  collision_det  in   1   from collision_detector, DET_LAT cycles after probe
//  probe_h        out  12  probe x, to collision_detector hcount_in
//  probe_v        out  12  probe y, to collision_detector vcount_in
//  xpos           out  12  ball top-left x
//  ypos           out  12  ball top-left y
//  ball_lost      out  1   high in LOST until next start
//  busy           out  1   high in PROBE_X..UPDATE
// BEHAVIOUR
//  - Reset: state=IDLE, xpos=START_X, ypos=START_Y, dx=+1, dy=-1 (up), probe_h=probe_v=0,
//    ball_lost=0, busy=0. Reset wins over every other input in the same cycle.
//  - All outputs registered. dx/dy each 1 bit (1 = +, 0 = -). Coordinates unsigned 12 bit.
//  - States: IDLE -start-> WAIT_TICK -frame_tick-> PROBE_X -> SAMPLE_X -> PROBE_Y ->
//    SAMPLE_Y -> UPDATE -> WAIT_TICK (or LOST). LOST -start-> WAIT_TICK.
//  - start (IDLE or LOST): load START_X/START_Y, dx=+1, dy=-1, ball_lost=0. In other states
//    start is ignored.
//  - PROBE_X: probe_h = dx ? xpos+BALL_SIZE : xpos-1; probe_v = ypos+BALL_SIZE/2.
//    SAMPLE_X waits DET_LAT cycles (counter), captures hit_x = collision_det on last cycle.
//  - PROBE_Y: probe_h = xpos+BALL_SIZE/2; probe_v = dy ? ypos+BALL_SIZE : ypos-1.
//    SAMPLE_Y mirrors SAMPLE_X -> hit_y. probe_h/v park at 0,0 on leaving SAMPLE_Y.
//  - Wall rules, UPDATE: wall_x = (dx & xpos==SCREEN_W-BALL_SIZE) | (!dx & xpos==0);
//    wall_top = (!dy & ypos==0). Flip dx on hit_x|wall_x, flip dy on hit_y|wall_top;
//    axis moves 1 px in the (new) direction. Both axes may flip in one UPDATE (corner).
//  - Bottom: if dy & ypos==SCREEN_H-BALL_SIZE at UPDATE -> no move, ball_lost=1, -> LOST.
//  - frame_tick outside WAIT_TICK is dropped (no queueing); ~2*DET_LAT+4 cycles per frame.
//  - collision_det sampled only on last SAMPLE_x cycle; other values are don't-care.
//  - busy = 1 exactly in PROBE_X, SAMPLE_X, PROBE_Y, SAMPLE_Y, UPDATE.
// STRUCTURE
//  - Shared include ball_params.v: state encodings (3 bit), BALL_SIZE, SCREEN_W/H,
//    direction constants; used beside blocks_coordinates.v.
//  - One sub-module: ball_probe_gen (combinational: xpos,ypos,dx,dy,axis -> probe point);
//    FSM, latency counter, position/direction registers stay in ball_controller.
//  - Bench instantiates real collision_detector to close the DET_LAT=1 loop.
// TESTING
//  1 rst, start, 3 frame_ticks, no hits -> xpos 396->399, ypos 500->497, ball_lost=0.
//  2 ball at x=SCREEN_W-8=792, dx=+1, tick -> dx=0, xpos=791 after UPDATE.
//  3 ball at (0,0), dx=0, dy=0, tick -> both flip, ball at (1,1) (corner).
//  4 place ball so right probe lands on a block left edge (HOR1-1 top-left x+8=HOR1),
//    collision_det asserts -> dx flips, x decrements; DET_LAT=2 and 3 give same result.
//  5 ypos=592, dy=1, tick -> ball_lost=1, LOST; tick ignored; start -> (396,500), up.
//  6 frame_tick while busy and rst mid-SAMPLE_Y -> tick dropped; rst gives reset values.

Source files
------------

// File: rtl/ball_controller_pkg.sv
// Shared types and constants for the breakout ball controller.
// Holds the FSM state encoding (3 bit), playfield geometry defaults,
// direction constants and the probe axis selector.
package ball_controller_pkg;

  localparam int COORD_W       = 12;
  localparam int SCREEN_W_DEF  = 800;
  localparam int SCREEN_H_DEF  = 600;
  localparam int BALL_SIZE_DEF = 8;
  localparam int START_X_DEF   = 396;
  localparam int START_Y_DEF   = 500;

  // Direction bits: 1 moves toward larger coordinates.
  localparam logic DIR_POS = 1'b1;
  localparam logic DIR_NEG = 1'b0;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_TICK = 3'd1,
    S_PROBE_X   = 3'd2,
    S_SAMPLE_X  = 3'd3,
    S_PROBE_Y   = 3'd4,
    S_SAMPLE_Y  = 3'd5,
    S_UPDATE    = 3'd6,
    S_LOST      = 3'd7
  } state_e;

  typedef enum logic {
    AXIS_X = 1'b0,
    AXIS_Y = 1'b1
  } axis_e;

  // Frame-processing states; the ball is moving through its per-frame sequence.
  function automatic logic state_is_busy(input state_e s);
    return (s == S_PROBE_X) || (s == S_SAMPLE_X) || (s == S_PROBE_Y) ||
           (s == S_SAMPLE_Y) || (s == S_UPDATE);
  endfunction

endpackage

// File: rtl/ball_probe_gen.sv
// Purpose : picks the playfield point just ahead of the ball's leading edge on one axis.
// Latency : combinational.
// Backpressure: none; caller registers the result when it issues the probe.
// Ports   : xpos/ypos ball top-left, dx/dy direction bits, axis selects which edge,
//           probe_h/probe_v the point handed to the collision detector.
module ball_probe_gen
  import ball_controller_pkg::*;
#(
  parameter int BALL_SIZE = BALL_SIZE_DEF
) (
  input  logic [COORD_W-1:0] xpos,
  input  logic [COORD_W-1:0] ypos,
  input  logic               dx,
  input  logic               dy,
  input  axis_e              axis,
  output logic [COORD_W-1:0] probe_h,
  output logic [COORD_W-1:0] probe_v
);

  localparam logic [COORD_W-1:0] SIZE = COORD_W'(BALL_SIZE);
  localparam logic [COORD_W-1:0] HALF = COORD_W'(BALL_SIZE / 2);
  localparam logic [COORD_W-1:0] ONE  = COORD_W'(1);

  // X probe sits mid-height on the leading vertical edge, Y probe mid-width on
  // the leading horizontal edge. Moving negative probes one pixel outside the
  // ball, so position 0 probes coordinate 4095 (wraps, never a block).
  always_comb begin
    probe_h = '0;
    probe_v = '0;
    if (axis == AXIS_X) begin
      probe_h = dx ? (xpos + SIZE) : (xpos - ONE);
      probe_v = ypos + HALF;
    end else begin
      probe_h = xpos + HALF;
      probe_v = dy ? (ypos + SIZE) : (ypos - ONE);
    end
  end

endmodule

// File: rtl/ball_controller.sv
// Purpose : owns ball position/direction; per frame probes the collision detector on
//           each axis, reflects on blocks and walls, then moves the ball 1 px per axis.
// Latency : 2*DET_LAT+4 pclk from frame_tick to updated xpos/ypos; ticks arriving
//           while busy are dropped (no queueing, no backpressure to the source).
// Ports   : pclk/rst (sync, active high), start serve pulse, frame_tick per-frame pulse,
//           collision_det from detector; probe_h/probe_v to detector, xpos/ypos ball
//           top-left, ball_lost while waiting for a new serve, busy during a frame.
module ball_controller
  import ball_controller_pkg::*;
#(
  parameter int SCREEN_W  = SCREEN_W_DEF,
  parameter int SCREEN_H  = SCREEN_H_DEF,
  parameter int BALL_SIZE = BALL_SIZE_DEF,
  parameter int START_X   = START_X_DEF,
  parameter int START_Y   = START_Y_DEF,
  parameter int DET_LAT   = 1
) (
  input  logic               pclk,
  input  logic               rst,
  input  logic               start,
  input  logic               frame_tick,
  input  logic               collision_det,
  output logic [COORD_W-1:0] probe_h,
  output logic [COORD_W-1:0] probe_v,
  output logic [COORD_W-1:0] xpos,
  output logic [COORD_W-1:0] ypos,
  output logic               ball_lost,
  output logic               busy
);

  localparam logic [COORD_W-1:0] X_INIT   = COORD_W'(START_X);
  localparam logic [COORD_W-1:0] Y_INIT   = COORD_W'(START_Y);
  localparam logic [COORD_W-1:0] X_MAX    = COORD_W'(SCREEN_W - BALL_SIZE);
  localparam logic [COORD_W-1:0] Y_MAX    = COORD_W'(SCREEN_H - BALL_SIZE);
  localparam logic [COORD_W-1:0] ONE      = COORD_W'(1);
  localparam logic [1:0]         LAT_LAST = 2'(DET_LAT - 1);

  state_e             state_q, state_d;
  logic [COORD_W-1:0] xpos_q, xpos_d;
  logic [COORD_W-1:0] ypos_q, ypos_d;
  logic               dx_q, dx_d;
  logic               dy_q, dy_d;
  logic [1:0]         lat_cnt_q, lat_cnt_d;
  logic               hit_x_q, hit_x_d;
  logic               hit_y_q, hit_y_d;
  logic [COORD_W-1:0] probe_h_q, probe_h_d;
  logic [COORD_W-1:0] probe_v_q, probe_v_d;
  logic               ball_lost_q, ball_lost_d;
  logic               busy_q, busy_d;

  axis_e              pg_axis;
  logic [COORD_W-1:0] pg_h;
  logic [COORD_W-1:0] pg_v;
  logic               lat_last;
  logic               wall_x;
  logic               wall_top;
  logic               at_bottom;
  logic               dx_new;
  logic               dy_new;

  // The probe is registered on entry to PROBE_X/PROBE_Y, so the only time the
  // Y probe is loaded is while leaving SAMPLE_X; every other load is the X probe.
  assign pg_axis = (state_q == S_SAMPLE_X) ? AXIS_Y : AXIS_X;

  ball_probe_gen #(
    .BALL_SIZE (BALL_SIZE)
  ) u_probe_gen (
    .xpos    (xpos_q),
    .ypos    (ypos_q),
    .dx      (dx_q),
    .dy      (dy_q),
    .axis    (pg_axis),
    .probe_h (pg_h),
    .probe_v (pg_v)
  );

  assign lat_last  = (lat_cnt_q == LAT_LAST);
  assign wall_x    = dx_q ? (xpos_q == X_MAX) : (xpos_q == '0);
  assign wall_top  = !dy_q && (ypos_q == '0);
  assign at_bottom = dy_q && (ypos_q == Y_MAX);
  assign dx_new    = dx_q ^ (hit_x_q | wall_x);
  assign dy_new    = dy_q ^ (hit_y_q | wall_top);

  always_comb begin
    state_d     = state_q;
    xpos_d      = xpos_q;
    ypos_d      = ypos_q;
    dx_d        = dx_q;
    dy_d        = dy_q;
    lat_cnt_d   = lat_cnt_q;
    hit_x_d     = hit_x_q;
    hit_y_d     = hit_y_q;
    probe_h_d   = probe_h_q;
    probe_v_d   = probe_v_q;
    ball_lost_d = ball_lost_q;

    case (state_q)
      S_IDLE, S_LOST: begin
        if (start) begin
          xpos_d      = X_INIT;
          ypos_d      = Y_INIT;
          dx_d        = DIR_POS;
          dy_d        = DIR_NEG;
          ball_lost_d = 1'b0;
          state_d     = S_WAIT_TICK;
        end
      end
      S_WAIT_TICK: begin
        if (frame_tick) begin
          probe_h_d = pg_h;
          probe_v_d = pg_v;
          state_d   = S_PROBE_X;
        end
      end
      S_PROBE_X: begin
        lat_cnt_d = '0;
        state_d   = S_SAMPLE_X;
      end
      S_SAMPLE_X: begin
        // Detector output is only meaningful on the final wait cycle.
        if (lat_last) begin
          hit_x_d   = collision_det;
          probe_h_d = pg_h;
          probe_v_d = pg_v;
          state_d   = S_PROBE_Y;
        end else begin
          lat_cnt_d = lat_cnt_q + 2'd1;
        end
      end
      S_PROBE_Y: begin
        lat_cnt_d = '0;
        state_d   = S_SAMPLE_Y;
      end
      S_SAMPLE_Y: begin
        if (lat_last) begin
          hit_y_d   = collision_det;
          probe_h_d = '0;
          probe_v_d = '0;
          state_d   = S_UPDATE;
        end else begin
          lat_cnt_d = lat_cnt_q + 2'd1;
        end
      end
      S_UPDATE: begin
        // Reaching the bottom edge while descending ends the serve in place.
        if (at_bottom) begin
          ball_lost_d = 1'b1;
          state_d     = S_LOST;
        end else begin
          dx_d    = dx_new;
          dy_d    = dy_new;
          xpos_d  = dx_new ? (xpos_q + ONE) : (xpos_q - ONE);
          ypos_d  = dy_new ? (ypos_q + ONE) : (ypos_q - ONE);
          state_d = S_WAIT_TICK;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = state_is_busy(state_d);
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      xpos_q      <= X_INIT;
      ypos_q      <= Y_INIT;
      dx_q        <= DIR_POS;
      dy_q        <= DIR_NEG;
      lat_cnt_q   <= '0;
      hit_x_q     <= 1'b0;
      hit_y_q     <= 1'b0;
      probe_h_q   <= '0;
      probe_v_q   <= '0;
      ball_lost_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      xpos_q      <= xpos_d;
      ypos_q      <= ypos_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
      lat_cnt_q   <= lat_cnt_d;
      hit_x_q     <= hit_x_d;
      hit_y_q     <= hit_y_d;
      probe_h_q   <= probe_h_d;
      probe_v_q   <= probe_v_d;
      ball_lost_q <= ball_lost_d;
      busy_q      <= busy_d;
    end
  end

  assign probe_h   = probe_h_q;
  assign probe_v   = probe_v_q;
  assign xpos      = xpos_q;
  assign ypos      = ypos_q;
  assign ball_lost = ball_lost_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_ball_controller.sv
// Bench for ball_controller: three instances (DET_LAT 1, 2, 3) share stimulus, each
// closed through a registered block-map detector model of matching latency.
// Expected end-of-frame positions are queued per instance and popped when busy falls.
module tb_ball_controller;

  typedef struct packed {
    logic [11:0] x;
    logic [11:0] y;
    logic        lost;
  } exp_t;

  logic pclk = 1'b0;
  logic rst;
  logic start;
  logic frame_tick;
  logic blocks_en;

  int checks = 0;
  int errors = 0;

  exp_t exp_q[3][$];
  logic prev_busy[3];

  always #5 pclk = ~pclk;

  // One block: left edge at x=456, spans x 456..519, y 448..463.
  function automatic logic blk_hit(input logic [11:0] h, input logic [11:0] v);
    return blocks_en && (h >= 12'd456) && (h <= 12'd519) && (v >= 12'd448) && (v <= 12'd463);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LAT = g + 1;
    logic [11:0] probe_h, probe_v, xpos, ypos;
    logic        ball_lost, busy, collision_det;
    logic [2:0]  det_sr = 3'b000;

    ball_controller #(.DET_LAT(LAT)) dut (
      .pclk          (pclk),
      .rst           (rst),
      .start         (start),
      .frame_tick    (frame_tick),
      .collision_det (collision_det),
      .probe_h       (probe_h),
      .probe_v       (probe_v),
      .xpos          (xpos),
      .ypos          (ypos),
      .ball_lost     (ball_lost),
      .busy          (busy)
    );

    always @(posedge pclk) det_sr <= {det_sr[1:0], blk_hit(probe_h, probe_v)};
    assign collision_det = det_sr[LAT-1];
  end

  task automatic step(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  task automatic mon_one(input int i, input logic b, input logic [11:0] x,
                         input logic [11:0] y, input logic l);
    exp_t got, want;
    if (prev_busy[i] === 1'b1 && b === 1'b0) begin
      got = {x, y, l};
      checks++;
      if (exp_q[i].size() == 0) begin
        errors++;
        $display("FAIL frame_extra lat=%0d got x=%0d y=%0d lost=%0d required no frame", i + 1, x, y, l);
      end else begin
        want = exp_q[i].pop_front();
        if (got !== want) begin
          errors++;
          $display("FAIL frame lat=%0d got x=%0d y=%0d lost=%0d required x=%0d y=%0d lost=%0d",
                   i + 1, x, y, l, want.x, want.y, want.lost);
        end
      end
    end
    prev_busy[i] = b;
  endtask

  task automatic monitor();
    forever begin
      @(negedge pclk);
      if (rst === 1'b1) begin
        for (int i = 0; i < 3; i++) prev_busy[i] = 1'b0;
      end else begin
        mon_one(0, g_dut[0].busy, g_dut[0].xpos, g_dut[0].ypos, g_dut[0].ball_lost);
        mon_one(1, g_dut[1].busy, g_dut[1].xpos, g_dut[1].ypos, g_dut[1].ball_lost);
        mon_one(2, g_dut[2].busy, g_dut[2].xpos, g_dut[2].ypos, g_dut[2].ball_lost);
      end
    end
  endtask

  // Idle-state check: position, lost, busy and parked probes.
  task automatic chk_one(input string name, input int i, input logic [11:0] x, input logic [11:0] y,
                         input logic l, input logic b, input logic [11:0] ph, input logic [11:0] pv,
                         input int ex, input int ey, input logic el, input logic eb);
    checks++;
    if ({x, y, l, b, ph, pv} !== {12'(ex), 12'(ey), el, eb, 24'd0}) begin
      errors++;
      $display("FAIL %s lat=%0d got x=%0d y=%0d lost=%0d busy=%0d ph=%0d pv=%0d required x=%0d y=%0d lost=%0d busy=%0d ph=0 pv=0",
               name, i + 1, x, y, l, b, ph, pv, ex, ey, el, eb);
    end
  endtask

  task automatic chk_all(input string name, input int ex, input int ey, input logic el, input logic eb);
    chk_one(name, 0, g_dut[0].xpos, g_dut[0].ypos, g_dut[0].ball_lost, g_dut[0].busy,
            g_dut[0].probe_h, g_dut[0].probe_v, ex, ey, el, eb);
    chk_one(name, 1, g_dut[1].xpos, g_dut[1].ypos, g_dut[1].ball_lost, g_dut[1].busy,
            g_dut[1].probe_h, g_dut[1].probe_v, ex, ey, el, eb);
    chk_one(name, 2, g_dut[2].xpos, g_dut[2].ypos, g_dut[2].ball_lost, g_dut[2].busy,
            g_dut[2].probe_h, g_dut[2].probe_v, ex, ey, el, eb);
  endtask

  task automatic chk_busy(input string name, input int i, input logic b);
    checks++;
    if (b !== 1'b1) begin
      errors++;
      $display("FAIL %s lat=%0d got busy=%0d required busy=1", name, i + 1, b);
    end
  endtask

  task automatic push_exp(input int ex, input int ey, input logic el);
    exp_t e;
    e.x    = 12'(ex);
    e.y    = 12'(ey);
    e.lost = el;
    for (int i = 0; i < 3; i++) exp_q[i].push_back(e);
  endtask

  task automatic pulse_tick();
    frame_tick = 1'b1;
    step(1);
    frame_tick = 1'b0;
  endtask

  task automatic frame(input int ex, input int ey, input logic el);
    push_exp(ex, ey, el);
    pulse_tick();
    step(11);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(3);
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    frame_tick = 1'b0;
    blocks_en  = 1'b1;
    for (int i = 0; i < 3; i++) prev_busy[i] = 1'b0;
    fork
      monitor();
    join_none

    step(3);
    rst = 1'b0;
    step(1);
    chk_all("reset", 396, 500, 1'b0, 1'b0);

    // Tick before any serve is ignored.
    pulse_tick();
    step(11);
    chk_all("idle_tick", 396, 500, 1'b0, 1'b0);

    pulse_start();
    chk_all("start", 396, 500, 1'b0, 1'b0);

    // Up-right diagonal; first three frames give (399,497).
    for (int n = 1; n <= 52; n++) frame(396 + n, 500 - n, 1'b0);
    // At (448,448) the right probe lands on x=456, the block's left edge.
    frame(447, 447, 1'b0);
    for (int k = 1; k <= 447; k++) frame(447 - k, 447 - k, 1'b0);
    blocks_en = 1'b0;
    // From (0,0) moving up-left: both walls at once.
    frame(1, 1, 1'b0);
    for (int k = 1; k <= 591; k++) frame(1 + k, 1 + k, 1'b0);
    // At y=592 descending: lost, no move.
    frame(592, 592, 1'b1);
    chk_all("lost", 592, 592, 1'b1, 1'b0);

    pulse_tick();
    step(11);
    chk_all("lost_tick", 592, 592, 1'b1, 1'b0);

    pulse_start();
    chk_all("restart", 396, 500, 1'b0, 1'b0);

    for (int n = 1; n <= 396; n++) frame(396 + n, 500 - n, 1'b0);
    // Right wall at x=792.
    frame(791, 103, 1'b0);
    frame(790, 102, 1'b0);

    // Second tick lands while busy and must be dropped.
    push_exp(789, 101, 1'b0);
    pulse_tick();
    step(2);
    pulse_tick();
    step(20);
    chk_all("busy_tick", 789, 101, 1'b0, 1'b0);

    // Reset mid-frame (SAMPLE_Y for DET_LAT=1).
    pulse_tick();
    step(3);
    chk_busy("mid_frame_busy", 0, g_dut[0].busy);
    chk_busy("mid_frame_busy", 1, g_dut[1].busy);
    chk_busy("mid_frame_busy", 2, g_dut[2].busy);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(2);
    chk_all("rst_mid", 396, 500, 1'b0, 1'b0);

    step(20);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (exp_q[i].size() != 0) begin
        errors++;
        $display("FAIL frames_missing lat=%0d got pending=%0d required pending=0", i + 1, exp_q[i].size());
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
